// File: rtl/cp0_except_commit_if.sv
// M-stage to CP0 commit bundle: exception code, MTC0/MFC0 access and CP0 state outputs.
interface cp0_except_commit_if;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [5:0]  int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        timer_int_o;
  logic        flush_o;
  logic [31:0] newpc_o;

  modport master (
    output excepttype_i, current_inst_addr_i, is_in_delayslot_i, bad_addr_i, int_i,
           we_i, waddr_i, wdata_i, raddr_i,
    input  rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o,
           timer_int_o, flush_o, newpc_o
  );

  modport slave (
    input  excepttype_i, current_inst_addr_i, is_in_delayslot_i, bad_addr_i, int_i,
           we_i, waddr_i, wdata_i, raddr_i,
    output rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o,
           timer_int_o, flush_o, newpc_o
  );
endinterface

// File: rtl/cp0_except_commit.sv
// CP0 subset with exception/ERET commit, redirect generation, MTC0/MFC0 and Count/Compare timer.
module cp0_except_commit #(
  parameter logic [31:0] EXC_BASE   = 32'hBFC00200,
  parameter bit          COUNT_DIV2 = 1'b1
) (
  input logic              clk,
  input logic              rst,
  cp0_except_commit_if.slave bus
);
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] badvaddr, count, compare, status, epc;
  logic        cause_bd, ti, div_tgl;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exccode;
  logic [31:0] cause;

  logic        exc_valid, upd_bad, eret, exl, tick;
  logic [4:0]  exc_map;
  logic        wr, wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  always_comb begin
    exc_valid = 1'b1;
    upd_bad   = 1'b0;
    exc_map   = 5'h00;
    case (bus.excepttype_i)
      32'h01: exc_map = 5'h00;
      32'h04: begin exc_map = 5'h04; upd_bad = 1'b1; end
      32'h05: begin exc_map = 5'h05; upd_bad = 1'b1; end
      32'h08: exc_map = 5'h08;
      32'h09: exc_map = 5'h09;
      32'h0a: exc_map = 5'h0a;
      32'h0b: exc_map = 5'h0b;
      32'h0c: exc_map = 5'h0c;
      32'h0d: exc_map = 5'h0d;
      32'h10, 32'h11, 32'h12: begin exc_map = 5'h02; upd_bad = 1'b1; end
      32'h13: begin exc_map = 5'h03; upd_bad = 1'b1; end
      32'h14: begin exc_map = 5'h01; upd_bad = 1'b1; end
      default: exc_valid = 1'b0;
    endcase
  end

  assign eret = (bus.excepttype_i == 32'h0e);
  assign exl  = status[1];
  assign tick = COUNT_DIV2 ? div_tgl : 1'b1;

  // A committing exception or ERET swallows any MTC0 in the same cycle.
  assign wr         = bus.we_i && !exc_valid && !eret;
  assign wr_status  = wr && (bus.waddr_i == REG_STATUS);
  assign wr_cause   = wr && (bus.waddr_i == REG_CAUSE);
  assign wr_epc     = wr && (bus.waddr_i == REG_EPC);
  assign wr_count   = wr && (bus.waddr_i == REG_COUNT);
  assign wr_compare = wr && (bus.waddr_i == REG_COMPARE);

  assign cause = {cause_bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exccode, 2'b0};

  always_comb begin
    bus.flush_o = 1'b0;
    bus.newpc_o = 32'h0;
    if (!rst) begin
      if (eret) begin
        bus.flush_o = 1'b1;
        bus.newpc_o = epc;
      end else if (exc_valid) begin
        bus.flush_o = 1'b1;
        // TLB refill misses take the refill vector only from non-EXL context.
        if (!exl && (bus.excepttype_i == 32'h10 || bus.excepttype_i == 32'h12))
          bus.newpc_o = EXC_BASE;
        else
          bus.newpc_o = EXC_BASE + 32'h180;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= 32'h0;
      count    <= 32'h0;
      compare  <= 32'h0;
      status   <= 32'h0040_0000;
      epc      <= 32'h0;
      cause_bd <= 1'b0;
      ti       <= 1'b0;
      div_tgl  <= 1'b0;
      ip_hw    <= 6'h0;
      ip_sw    <= 2'h0;
      exccode  <= 5'h0;
    end else begin
      div_tgl <= wr_count ? 1'b0 : ~div_tgl;
      if (wr_count)  count <= bus.wdata_i;
      else if (tick) count <= count + 32'd1;

      if (wr_compare) compare <= bus.wdata_i;
      if (wr_compare) ti <= 1'b0;
      else if (count == compare && compare != 32'h0) ti <= 1'b1;

      ip_hw <= {bus.int_i[5] | ti, bus.int_i[4:0]};

      if (wr_status) begin
        status[15:8] <= bus.wdata_i[15:8];
        status[1:0]  <= bus.wdata_i[1:0];
      end
      if (wr_cause) ip_sw <= bus.wdata_i[9:8];
      if (wr_epc)   epc   <= bus.wdata_i;

      if (exc_valid) begin
        status[1] <= 1'b1;
        exccode   <= exc_map;
        if (!exl) begin
          cause_bd <= bus.is_in_delayslot_i;
          epc      <= bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                            : bus.current_inst_addr_i;
        end
        if (upd_bad) badvaddr <= bus.bad_addr_i;
      end
      if (eret) status[1] <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata_o = 32'h0;
    case (bus.raddr_i)
      REG_BADVADDR: bus.rdata_o = badvaddr;
      REG_COUNT:    bus.rdata_o = count;
      REG_COMPARE:  bus.rdata_o = compare;
      REG_STATUS:   bus.rdata_o = status;
      REG_CAUSE:    bus.rdata_o = cause;
      REG_EPC:      bus.rdata_o = epc;
      default:      bus.rdata_o = 32'h0;
    endcase
  end

  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.badvaddr_o  = badvaddr;
  assign bus.count_o     = count;
  assign bus.compare_o   = compare;
  assign bus.timer_int_o = ti;
endmodule

// File: doc/cp0_except_commit.md
Name: cp0_except_commit

Overview:
- Memory-stage consumer of the prioritised exception code (excepttype) produced by the exception classifier.
- Holds the architectural CP0 subset: BadVAddr, Count, Compare, Status, Cause and EPC.
- Commits exception entry and ERET, drives the pipeline flush and redirect PC, samples interrupt lines and runs the Count/Compare timer.
- Its Status/Cause outputs feed back into the exception classifier the same cycle.

Parameters:
- EXC_BASE, 32'hBFC00200, refill vector; the general vector is EXC_BASE+32'h180.
- COUNT_DIV2, 1, 1 = Count increments every second clk; 0 = every clk.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- excepttype_i  in  32  M-stage exception code; 0 = none
- current_inst_addr_i  in  32  PC of the M-stage instruction
- is_in_delayslot_i  in  1  M-stage instruction is in a delay slot
- bad_addr_i  in  32  faulting virtual address (fetch or data)
- int_i  in  6  external hardware interrupts, level
- we_i  in  1  MTC0 write enable (M stage)
- waddr_i  in  5  CP0 register number
- wdata_i  in  32  MTC0 data
- raddr_i  in  5  MFC0 read register number
- rdata_o  out  32  MFC0 read data, combinational
- status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  out  32 each  register values
- timer_int_o  out  1  Compare-match pending (Cause.TI)
- flush_o  out  1  flush all stages, combinational
- newpc_o  out  32  redirect target, valid when flush_o=1

Behaviour:
- Reset values: Status=32'h0040_0000 (BEV=1); all other registers 0, including the Count divider toggle; timer_int_o=0.
- During reset, flush_o=0 and newpc_o=0.

Exception code map (excepttype_i → Cause.ExcCode):
- 01→0x00 (Int)
- 04→0x04 (AdEL)
- 05→0x05 (AdES)
- 08→0x08 (Sys)
- 09→0x09 (Bp)
- 0a→0x0a (RI)
- 0b→0x0b (CpU)
- 0c→0x0c (Ov)
- 0d→0x0d (Tr)
- 10, 11, 12→0x02 (TLBL)
- 13→0x03 (TLBS)
- 14→0x01 (Mod)
- 0e = ERET, not an exception.
- Any other nonzero code: flush_o=0, no state change.

Exception entry (valid code other than 0e), at the next clk edge:
- Status.EXL←1.
- Cause.ExcCode←mapped code; Cause.BD←is_in_delayslot_i.
- If Status.EXL was already 1, EPC and BD are NOT updated.
- Otherwise EPC←is_in_delayslot_i ? current_inst_addr_i−4 : current_inst_addr_i.
- BadVAddr←bad_addr_i for codes 04, 05, 10–14 only.

Exception redirect (same cycle as entry, combinational):
- flush_o=1.
- newpc_o=EXC_BASE for codes 10 and 12 when Status.EXL=0; EXC_BASE+32'h180 otherwise.

ERET (code 0e):
- flush_o=1, newpc_o=EPC current value.
- Status.EXL←0 at the edge.

MTC0 (we_i=1, applied at the edge) — writable fields:
- Status: IM[15:8], EXL[1], IE[0].
- Cause: IP[9:8].
- EPC, Compare, Count: all 32 bits.
- Writes to other fields or registers are ignored.

Simultaneous events:
- Exception or ERET in the same cycle as we_i: the MTC0 write is dropped entirely.
- Writing Count in the same cycle as an increment: the written value wins and the divider toggle clears.

Timer:
- Count increments per COUNT_DIV2 and wraps 32'hFFFFFFFF→0.
- When Count==Compare (Compare≠0) and no Compare write is happening: TI←1 at the next edge.
- TI is sticky until any MTC0 to Compare clears it.

Interrupt sampling:
- Every cycle Cause.IP[15:10]←{int_i[5]|TI, int_i[4:0]}.
- Cause[30]=TI.

MFC0 read (rdata_o):
- Registers 8, 9, 11, 12, 13, 14 return BadVAddr, Count, Compare, Status, Cause, EPC. All others return 0.
- Pre-edge values are returned; there is no write-to-read bypass.

Test Plan:
- Reset, then idle: status_o=32'h00400000, flush_o=0. Read reg 12 → 32'h00400000. Count reaches 5 after 10 clk (COUNT_DIV2=1).
- excepttype_i=08, PC=32'hBFC00100, not delay slot, EXL=0 → flush_o=1 and newpc_o=32'hBFC00380 that cycle. Next cycle: EPC=32'hBFC00100, ExcCode=0x08, EXL=1, BD=0.
- excepttype_i=04, delay slot, PC=32'h80000010, bad_addr=32'h80000011 → EPC=32'h8000000C, BD=1, BadVAddr=32'h80000011, ExcCode=0x04.
- EXL=1 with EPC=32'h1234, then excepttype_i=0c → EPC stays 32'h1234, ExcCode=0x0c. Then excepttype_i=0e → newpc_o=32'h1234, EXL←0.
- MTC0 Compare=20, Count=10 → TI=1 and int_i-merged Cause[15]=1 after Count hits 20. MTC0 Compare=100 → TI=0.
- we_i=1 to Status with wdata=0, same cycle as excepttype_i=0a → Status.EXL=1 and IM unchanged (write dropped). excepttype_i=10 with EXL=0 → newpc_o=32'hBFC00200.
